// File: rtl/sd_boot_pkg.sv
// Shared types and constants for the SD boot loader: FSM states, SPI-mode
// token values, block geometry and abort codes.
package sd_boot_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SEND_CMD,
      S_WAIT_R1,
      S_TOKEN,
      S_DATA,
      S_CRC,
      S_NEXT,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [7:0] CMD17_OP   = 8'h51;
   localparam logic [7:0] DATA_TOKEN = 8'hFE;
   localparam logic [7:0] IDLE_BYTE  = 8'hFF;

   localparam int BLOCK_BYTES = 512;
   localparam int CRC_BYTES   = 2;

   localparam logic [2:0] ERR_NONE          = 3'd0;
   localparam logic [2:0] ERR_R1            = 3'd1;
   localparam logic [2:0] ERR_TOKEN_TIMEOUT = 3'd2;
   localparam logic [2:0] ERR_BAD_TOKEN     = 3'd3;
   localparam logic [2:0] ERR_NOT_INIT      = 3'd4;
   localparam logic [2:0] ERR_R1_TIMEOUT    = 3'd5;

   // READ_SINGLE_BLOCK frame; the trailing byte stands in for the CRC, which
   // SPI mode ignores once init is complete.
   function automatic logic [47:0] cmd17_frame(input logic [31:0] blk_addr);
      return {CMD17_OP, blk_addr, IDLE_BYTE};
   endfunction

endpackage

// File: rtl/sd_byte_packer.sv
// Packs a stream of payload bytes into 32-bit little-endian words and emits a
// registered one-cycle write strobe with the word index on every fourth byte.
module sd_byte_packer
   import sd_boot_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [8:0]  byte_idx,
   output logic        word_we,
   output logic [31:0] word_data,
   output logic [6:0]  word_idx
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_idx  <= '0;
         word_we   <= 1'b0;
         word_data <= '0;
         word_idx  <= '0;
      end else begin
         word_we <= 1'b0;
         if (clear) begin
            byte_idx <= '0;
         end else if (byte_valid) begin
            byte_idx <= byte_idx + 9'd1;
            word_data[{byte_idx[1:0], 3'b000} +: 8] <= byte_data;
            if (byte_idx[1:0] == 2'd3) begin
               word_we  <= 1'b1;
               word_idx <= byte_idx[8:2];
            end
         end
      end
   end

endmodule

// File: rtl/sd_block_loader.sv
// Boot sequencer: after card init, reads NUM_BLOCKS consecutive SD blocks with
// CMD17 through the SPI byte engine and copies their payload into boot memory.
module sd_block_loader
   import sd_boot_pkg::*;
#(
   parameter logic [31:0] START_BLOCK = 32'd0,
   parameter int          NUM_BLOCKS  = 8,
   parameter int          ADDR_W      = 12,
   parameter int          R1_TIMEOUT  = 4096,
   parameter int          TOKEN_TRIES = 1024
)(
   input  logic              spi_clk_i,
   input  logic              spi_rst_i,
   input  logic              ld_start_i,
   input  logic              spi_initdone_i,
   input  logic              spi_ready_i,
   output logic [47:0]       spi_cmd_o,
   output logic              spi_cmd_valid_o,
   input  logic [7:0]        spi_r1_i,
   input  logic              spi_r1_valid_i,
   output logic              spi_rd_req_o,
   input  logic [7:0]        spi_byte_i,
   input  logic              spi_byte_valid_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              ld_busy_o,
   output logic              ld_done_o,
   output logic              ld_err_o,
   output logic [2:0]        ld_errcode_o
);

   localparam int R1_W  = $clog2(R1_TIMEOUT + 1);
   localparam int TRY_W = $clog2(TOKEN_TRIES + 1);
   localparam logic [R1_W-1:0]  R1_LAST   = R1_W'(R1_TIMEOUT - 1);
   localparam logic [TRY_W-1:0] TRY_LAST  = TRY_W'(TOKEN_TRIES - 1);
   localparam logic [8:0]       BLK_LAST  = 9'(NUM_BLOCKS - 1);
   localparam logic [8:0]       BYTE_LAST = 9'(BLOCK_BYTES - 1);
   localparam logic [1:0]       CRC_LAST  = 2'(CRC_BYTES - 1);

   state_t            state_q, state_d;
   logic [8:0]        blk_q;
   logic [R1_W-1:0]   r1_timer_q;
   logic [TRY_W-1:0]  tries_q;
   logic [1:0]        crc_cnt_q;
   logic              rd_pend_q;
   logic              done_q, err_q;
   logic [2:0]        errcode_q, errcode_d;

   logic              rd_state, rd_accept, cmd_accept, byte_ok, data_byte, last_byte;
   logic [8:0]        byte_idx;
   logic [6:0]        word_idx;

   // A byte strobe only counts when it answers a read we actually issued;
   // this also drops strobes that were in flight across a reset.
   assign rd_state        = state_q inside {S_TOKEN, S_DATA, S_CRC};
   assign spi_rd_req_o    = rd_state && !rd_pend_q;
   assign rd_accept       = spi_rd_req_o && spi_ready_i;
   assign spi_cmd_valid_o = (state_q == S_SEND_CMD);
   assign cmd_accept      = spi_cmd_valid_o && spi_ready_i;
   assign spi_cmd_o       = spi_cmd_valid_o ? cmd17_frame(START_BLOCK + 32'(blk_q)) : '0;
   assign byte_ok         = spi_byte_valid_i && rd_pend_q;
   assign data_byte       = byte_ok && (state_q == S_DATA);
   assign last_byte       = data_byte && (byte_idx == BYTE_LAST);

   assign ld_busy_o    = (state_q != S_IDLE);
   assign ld_done_o    = done_q;
   assign ld_err_o     = err_q;
   assign ld_errcode_o = errcode_q;
   assign mem_addr_o   = ADDR_W'({blk_q, word_idx});

   sd_byte_packer u_packer (
      .clk        (spi_clk_i),
      .rst        (spi_rst_i),
      .clear      (state_q == S_TOKEN),
      .byte_valid (data_byte),
      .byte_data  (spi_byte_i),
      .byte_idx   (byte_idx),
      .word_we    (mem_we_o),
      .word_data  (mem_wdata_o),
      .word_idx   (word_idx)
   );

   // NOTE: every signal driven here gets a default first, so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      errcode_d = errcode_q;
      case (state_q)
         S_IDLE: begin
            if (ld_start_i) begin
               if (spi_initdone_i) begin
                  state_d   = S_SEND_CMD;
                  errcode_d = ERR_NONE;
               end else begin
                  state_d   = S_ERROR;
                  errcode_d = ERR_NOT_INIT;
               end
            end
         end
         S_SEND_CMD: if (cmd_accept) state_d = S_WAIT_R1;
         S_WAIT_R1: begin
            if (spi_r1_valid_i) begin
               if (spi_r1_i == 8'h00) begin
                  state_d = S_TOKEN;
               end else begin
                  state_d   = S_ERROR;
                  errcode_d = ERR_R1;
               end
            end else if (r1_timer_q >= R1_LAST) begin
               state_d   = S_ERROR;
               errcode_d = ERR_R1_TIMEOUT;
            end
         end
         S_TOKEN: begin
            if (byte_ok) begin
               if (spi_byte_i == DATA_TOKEN) begin
                  state_d = S_DATA;
               end else if (spi_byte_i == IDLE_BYTE) begin
                  if (tries_q >= TRY_LAST) begin
                     state_d   = S_ERROR;
                     errcode_d = ERR_TOKEN_TIMEOUT;
                  end
               end else begin
                  state_d   = S_ERROR;
                  errcode_d = ERR_BAD_TOKEN;
               end
            end
         end
         S_DATA:  if (last_byte) state_d = S_CRC;
         S_CRC:   if (byte_ok && crc_cnt_q == CRC_LAST) state_d = S_NEXT;
         S_NEXT:  state_d = (blk_q == BLK_LAST) ? S_DONE : S_SEND_CMD;
         S_DONE:  state_d = S_IDLE;
         S_ERROR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge spi_clk_i) begin
      if (spi_rst_i) begin
         state_q    <= S_IDLE;
         errcode_q  <= ERR_NONE;
         blk_q      <= '0;
         r1_timer_q <= '0;
         tries_q    <= '0;
         crc_cnt_q  <= '0;
         rd_pend_q  <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         errcode_q <= errcode_d;

         if (rd_accept)             rd_pend_q <= 1'b1;
         else if (spi_byte_valid_i) rd_pend_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (ld_start_i) begin
                  done_q <= 1'b0;
                  err_q  <= 1'b0;
                  blk_q  <= '0;
               end
            end
            S_SEND_CMD: begin
               r1_timer_q <= '0;
               tries_q    <= '0;
               crc_cnt_q  <= '0;
            end
            S_WAIT_R1: if (r1_timer_q != '1) r1_timer_q <= r1_timer_q + 1'b1;
            S_TOKEN: begin
               if (byte_ok && spi_byte_i == IDLE_BYTE && tries_q != '1)
                  tries_q <= tries_q + 1'b1;
            end
            S_CRC:   if (byte_ok) crc_cnt_q <= crc_cnt_q + 2'd1;
            S_NEXT:  blk_q  <= blk_q + 9'd1;
            S_DONE:  done_q <= 1'b1;
            S_ERROR: err_q  <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_block_loader.sv
// Directed bench for sd_block_loader: a behavioural SPI engine answers commands
// and byte reads from a per-scenario byte stream; results come from a vector table.
`timescale 1ns/1ps
module tb_sd_block_loader;

   localparam int ADDR_W = 12;
   localparam int LAT    = 2;

   logic        clk = 1'b0;
   logic        spi_rst = 1'b1;
   logic        ld_start = 1'b0;
   logic        initdone = 1'b1;
   logic        ready = 1'b0;
   logic [7:0]  r1 = 8'h00;
   logic        r1_valid = 1'b0;
   logic [7:0]  byte_d = 8'h00;
   logic        byte_valid = 1'b0;

   logic [47:0]       spi_cmd_o;
   logic              spi_cmd_valid_o, spi_rd_req_o, mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_wdata_o;
   logic              ld_busy_o, ld_done_o, ld_err_o;
   logic [2:0]        ld_errcode_o;

   always #5 clk = ~clk;

   sd_block_loader #(
      .START_BLOCK (32'h0000_0100),
      .NUM_BLOCKS  (2),
      .ADDR_W      (ADDR_W),
      .R1_TIMEOUT  (64),
      .TOKEN_TRIES (16)
   ) dut (
      .spi_clk_i        (clk),
      .spi_rst_i        (spi_rst),
      .ld_start_i       (ld_start),
      .spi_initdone_i   (initdone),
      .spi_ready_i      (ready),
      .spi_cmd_o        (spi_cmd_o),
      .spi_cmd_valid_o  (spi_cmd_valid_o),
      .spi_r1_i         (r1),
      .spi_r1_valid_i   (r1_valid),
      .spi_rd_req_o     (spi_rd_req_o),
      .spi_byte_i       (byte_d),
      .spi_byte_valid_i (byte_valid),
      .mem_we_o         (mem_we_o),
      .mem_addr_o       (mem_addr_o),
      .mem_wdata_o      (mem_wdata_o),
      .ld_busy_o        (ld_busy_o),
      .ld_done_o        (ld_done_o),
      .ld_err_o         (ld_err_o),
      .ld_errcode_o     (ld_errcode_o)
   );

   // Scenario configuration, written only by the main sequence.
   logic [7:0] cfg_r1 = 8'h00;
   logic [7:0] cfg_token = 8'hFE;
   logic       cfg_silent = 1'b0;
   int         cfg_ff = 3;
   int         cfg_stall = 0;
   int         stray_req = 0;

   // Engine model state, written only by the engine process.
   typedef enum {E_IDLE, E_OFFER, E_BUSY} eng_t;
   eng_t        eng_st = E_IDLE;
   int          wait_cnt = 0, lat = 0, byte_pos = 0, stray_done = 0;
   int          rd_count = 0, cmd_count = 0, hold_err = 0, drop_err = 0;
   logic        is_cmd = 1'b0;
   logic [47:0] snap = '0;
   logic [47:0] cmd_log[$];

   // Memory-side monitor state.
   logic [ADDR_W-1:0] wr_addr_q[$];
   logic [31:0]       wr_data_q[$];
   logic              prev_we = 1'b0;
   int                pulse_err = 0, both_err = 0;

   int total = 0;
   int bad = 0;

   // Byte stream per command: cfg_ff idle bytes, a token, 512 payload bytes
   // counting 0x00..0xFF repeatedly, then CRC filler.
   function automatic logic [7:0] next_byte(input int pos);
      if (pos < cfg_ff)              return 8'hFF;
      if (pos == cfg_ff)             return cfg_token;
      if (pos < cfg_ff + 1 + 512)    return 8'((pos - cfg_ff - 1) % 256);
      return 8'hAA;
   endfunction

   always @(negedge clk) begin
      r1_valid   = 1'b0;
      byte_valid = 1'b0;
      if (spi_rst) begin
         eng_st   = E_IDLE;
         ready    = 1'b0;
         wait_cnt = 0;
      end else if (stray_req != stray_done) begin
         byte_d     = 8'h55;
         byte_valid = 1'b1;
         stray_done = stray_req;
      end else begin
         case (eng_st)
            E_IDLE: begin
               if (spi_cmd_valid_o || spi_rd_req_o) begin
                  if (wait_cnt == 0) snap = spi_cmd_o;
                  else if (spi_cmd_o != snap) hold_err++;
                  if (wait_cnt < cfg_stall) begin
                     ready = 1'b0;
                     wait_cnt++;
                  end else begin
                     ready  = 1'b1;
                     is_cmd = spi_cmd_valid_o;
                     eng_st = E_OFFER;
                  end
               end else begin
                  if (wait_cnt != 0) hold_err++;
                  ready = 1'b0;
               end
            end
            E_OFFER: begin
               ready    = 1'b0;
               wait_cnt = 0;
               if (spi_cmd_valid_o || spi_rd_req_o) drop_err++;
               if (is_cmd) begin
                  cmd_log.push_back(snap);
                  cmd_count++;
                  byte_pos = 0;
               end else begin
                  rd_count++;
               end
               lat    = LAT;
               eng_st = E_BUSY;
            end
            default: begin
               if (spi_cmd_valid_o || spi_rd_req_o) drop_err++;
               if (lat > 0) begin
                  lat--;
               end else begin
                  if (is_cmd) begin
                     if (!cfg_silent) begin
                        r1       = cfg_r1;
                        r1_valid = 1'b1;
                     end
                  end else begin
                     byte_d     = next_byte(byte_pos);
                     byte_valid = 1'b1;
                     byte_pos++;
                  end
                  eng_st = E_IDLE;
               end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (mem_we_o) begin
         wr_addr_q.push_back(mem_addr_o);
         wr_data_q.push_back(mem_wdata_o);
         if (prev_we) pulse_err++;
      end
      prev_we = mem_we_o;
      if (ld_done_o && ld_err_o) both_err++;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      string      name;
      logic       initdone;
      logic [7:0] r1;
      logic       silent;
      int         ff;
      logic [7:0] token;
      int         stall;
      logic       mid_start;
      logic       exp_done;
      logic       exp_err;
      logic [2:0] exp_code;
      int         exp_writes;
      int         exp_reads;
      int         exp_cmds;
   } vec_t;

   vec_t vecs[7];

   task automatic wait_idle(input string name, input int limit);
      int n;
      n = 0;
      while (ld_busy_o && n < limit) begin
         @(negedge clk);
         n++;
      end
      check({name, " busy falls"}, ld_busy_o, 1'b0);
   endtask

   task automatic check_words(input string name, input int wr0);
      int          nbad;
      int          k;
      logic [31:0] expw;
      nbad = 0;
      for (int j = 0; j < 256; j++) begin
         k    = 4 * (j % 128);
         expw = {8'(k + 3), 8'(k + 2), 8'(k + 1), 8'(k)};
         if (wr0 + j >= wr_addr_q.size()) nbad++;
         else if (wr_addr_q[wr0 + j] != ADDR_W'(j) || wr_data_q[wr0 + j] != expw) nbad++;
      end
      check({name, " word stream"}, nbad, 0);
      check({name, " addr0 data"}, wr_data_q[wr0], 32'h0302_0100);
      check({name, " addr0"}, wr_addr_q[wr0], 0);
      check({name, " addr128 data"}, wr_data_q[wr0 + 128], 32'h0302_0100);
      check({name, " addr128"}, wr_addr_q[wr0 + 128], 128);
      check({name, " addr127 data"}, wr_data_q[wr0 + 127], 32'hFFFE_FDFC);
   endtask

   task automatic run_vec(input vec_t v);
      int rd0, cmd0, wr0;
      cfg_r1     = v.r1;
      cfg_silent = v.silent;
      cfg_ff     = v.ff;
      cfg_token  = v.token;
      cfg_stall  = v.stall;
      initdone   = v.initdone;
      rd0  = rd_count;
      cmd0 = cmd_count;
      wr0  = wr_addr_q.size();
      @(negedge clk);
      ld_start = 1'b1;
      @(negedge clk);
      ld_start = 1'b0;
      check({v.name, " start latency"}, {ld_busy_o, spi_cmd_valid_o}, {1'b1, v.initdone});
      if (v.mid_start) begin
         repeat (200) @(negedge clk);
         ld_start = 1'b1;
         @(negedge clk);
         ld_start = 1'b0;
      end
      wait_idle(v.name, 40000);
      check({v.name, " done"}, ld_done_o, v.exp_done);
      check({v.name, " err"}, ld_err_o, v.exp_err);
      check({v.name, " errcode"}, ld_errcode_o, v.exp_code);
      check({v.name, " writes"}, wr_addr_q.size() - wr0, v.exp_writes);
      check({v.name, " reads"}, rd_count - rd0, v.exp_reads);
      check({v.name, " cmds"}, cmd_count - cmd0, v.exp_cmds);
      if (v.exp_cmds == 2) begin
         check({v.name, " frame0"}, cmd_log[cmd0], 48'h51_0000_0100_FF);
         check({v.name, " frame1"}, cmd_log[cmd0 + 1], 48'h51_0000_0101_FF);
      end
      if (v.exp_writes == 256) check_words(v.name, wr0);
   endtask

   initial begin
      int n, wr_before;
      // 3 idle bytes + token + 512 data + 2 CRC = 518 reads per block.
      vecs[0] = '{name:"clean", initdone:1'b1, r1:8'h00, silent:1'b0, ff:3, token:8'hFE,
                  stall:0, mid_start:1'b0, exp_done:1'b1, exp_err:1'b0, exp_code:3'd0,
                  exp_writes:256, exp_reads:1036, exp_cmds:2};
      vecs[1] = '{name:"r1_err", initdone:1'b1, r1:8'h05, silent:1'b0, ff:3, token:8'hFE,
                  stall:0, mid_start:1'b0, exp_done:1'b0, exp_err:1'b1, exp_code:3'd1,
                  exp_writes:0, exp_reads:0, exp_cmds:1};
      vecs[2] = '{name:"token_timeout", initdone:1'b1, r1:8'h00, silent:1'b0, ff:100, token:8'hFE,
                  stall:0, mid_start:1'b0, exp_done:1'b0, exp_err:1'b1, exp_code:3'd2,
                  exp_writes:0, exp_reads:16, exp_cmds:1};
      vecs[3] = '{name:"bad_token", initdone:1'b1, r1:8'h00, silent:1'b0, ff:2, token:8'h08,
                  stall:0, mid_start:1'b0, exp_done:1'b0, exp_err:1'b1, exp_code:3'd3,
                  exp_writes:0, exp_reads:3, exp_cmds:1};
      vecs[4] = '{name:"not_init", initdone:1'b0, r1:8'h00, silent:1'b0, ff:3, token:8'hFE,
                  stall:0, mid_start:1'b0, exp_done:1'b0, exp_err:1'b1, exp_code:3'd4,
                  exp_writes:0, exp_reads:0, exp_cmds:0};
      vecs[5] = '{name:"r1_timeout", initdone:1'b1, r1:8'h00, silent:1'b1, ff:3, token:8'hFE,
                  stall:0, mid_start:1'b0, exp_done:1'b0, exp_err:1'b1, exp_code:3'd5,
                  exp_writes:0, exp_reads:0, exp_cmds:1};
      vecs[6] = '{name:"stalled", initdone:1'b1, r1:8'h00, silent:1'b0, ff:3, token:8'hFE,
                  stall:10, mid_start:1'b1, exp_done:1'b1, exp_err:1'b0, exp_code:3'd0,
                  exp_writes:256, exp_reads:1036, exp_cmds:2};

      repeat (3) @(negedge clk);
      check("reset outputs", {spi_cmd_o, spi_cmd_valid_o, spi_rd_req_o, mem_we_o, mem_addr_o,
            mem_wdata_o, ld_busy_o, ld_done_o, ld_err_o, ld_errcode_o}, '0);
      spi_rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Reset in the middle of block 0's payload, then a stray byte strobe.
      cfg_r1 = 8'h00; cfg_silent = 1'b0; cfg_ff = 3; cfg_token = 8'hFE; cfg_stall = 0;
      initdone = 1'b1;
      @(negedge clk);
      ld_start = 1'b1;
      @(negedge clk);
      ld_start = 1'b0;
      n = 0;
      while (byte_pos < 3 + 1 + 301 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("midreset reached byte 300", byte_pos >= 305, 1'b1);
      spi_rst = 1'b1;
      @(negedge clk);
      check("midreset outputs", {spi_cmd_o, spi_cmd_valid_o, spi_rd_req_o, mem_we_o, mem_addr_o,
            mem_wdata_o, ld_busy_o, ld_done_o, ld_err_o, ld_errcode_o}, '0);
      wr_before = wr_addr_q.size();
      spi_rst   = 1'b0;
      stray_req++;
      repeat (5) @(negedge clk);
      check("stray byte busy", ld_busy_o, 1'b0);
      check("stray byte rd_req", spi_rd_req_o, 1'b0);
      check("stray byte writes", wr_addr_q.size() - wr_before, 0);
      vecs[0].name = "restart";
      run_vec(vecs[0]);

      check("request held while stalled", hold_err, 0);
      check("request drops after accept", drop_err, 0);
      check("write strobe one cycle", pulse_err, 0);
      check("done and err exclusive", both_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
